// File: rtl/prog_encoder_if.sv
// prog_encoder_if: field-bundle handshake from the host plus the IMEM write port.
interface prog_encoder_if #(parameter int ADDR_W = 10);
    logic              in_valid, in_ready, in_last, imm_en;
    logic [4:0]        op;
    logic [3:0]        rd, rs1, rs2;
    logic [17:0]       imm;
    logic [26:0]       offset;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    modport master (output in_valid, in_last, imm_en, op, rd, rs1, rs2, imm, offset,
                    input in_ready, imem_we, imem_addr, imem_wdata);
    modport slave  (input in_valid, in_last, imm_en, op, rd, rs1, rs2, imm, offset,
                    output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/prog_encoder.sv
// prog_encoder: packs SimpleRISC instruction fields into 32-bit words and writes them sequentially into IMEM.
module prog_encoder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    prog_encoder_if.slave     bus,
    output logic              busy,
    output logic              prog_done,
    output logic              err_illegal,
    output logic              full,
    output logic [ADDR_W:0]   word_count
);
    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d, last_q, last_d;
    logic [31:0]       word_q, word_d, enc;
    logic              rfmt, ldst, brn, rt, legal, ie, arm, acc;

    always_comb begin
        rfmt  = bus.op <= 5'd12;
        ldst  = bus.op[4:1] == 4'b0111;
        brn   = bus.op[4:2] == 3'b100;
        rt    = bus.op[4:1] == 4'b1010;
        legal = rfmt | ldst | brn | rt;
        ie    = bus.imm_en | ldst;
        enc   = brn ? {bus.op, bus.offset} :
                rt  ? {bus.op, 27'd0} :
                      {bus.op, ie, bus.rd, bus.rs1, ie ? bus.imm : {bus.rs2, 14'd0}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            last_q  <= last_d;
            word_q  <= word_d;
        end
    end

    // start is honoured only outside a session; an illegal op is consumed without a write
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        last_d  = last_q;
        word_d  = word_q;
        arm     = start && (state_q == IDLE || state_q == DONE);
        acc     = state_q == ACCEPT && bus.in_valid && bus.in_ready;
        if (arm) begin
            state_d = ACCEPT;
            ptr_d   = base_addr;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (acc && legal) begin
            state_d = WRITE;
            word_d  = enc;
            last_d  = bus.in_last;
        end else if (acc) begin
            err_d   = 1'b1;
            state_d = bus.in_last ? DONE : ACCEPT;
        end else if (state_q == WRITE) begin
            ptr_d   = ptr_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = (last_q || cnt_d == (ADDR_W+1)'(DEPTH)) ? DONE : ACCEPT;
        end
    end

    always_comb begin
        busy           = state_q == ACCEPT || state_q == WRITE;
        prog_done      = state_q == DONE;
        err_illegal    = err_q;
        full           = cnt_q == (ADDR_W+1)'(DEPTH);
        word_count     = cnt_q;
        bus.in_ready   = state_q == ACCEPT && !full;
        bus.imem_we    = state_q == WRITE;
        bus.imem_addr  = ptr_q;
        bus.imem_wdata = word_q;
    end
endmodule

// File: doc/prog_encoder.md
Name: prog_encoder

Overview:
Instruction-memory writer for the SimpleRISC core. It is the encode/write side of the instruction decoder.
- Accepts instruction fields (opcode, registers, immediate, offset) over a valid/ready handshake.
- Packs them into 32-bit SimpleRISC words.
- Writes the words sequentially into instruction memory from a base address.
- Sits between the debug/boot host interface and the IMEM write port. Used to load programs before the core is released from reset.

Parameters:
ADDR_W, 10, IMEM word-address width.
DEPTH, 1024, number of IMEM words; write counter limit (≤ 2^ADDR_W).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
start  input  1  one-cycle pulse; arms a load session.
base_addr  input  ADDR_W  first IMEM word address, sampled on start.
in_valid  input  1  field bundle valid.
in_ready  output  1  encoder can accept a bundle.
in_last  input  1  bundle is the final instruction of the session.
op  input  5  opcode, becomes word[31:27].
imm_en  input  1  immediate form, becomes word[26] for register-format opcodes.
rd  input  4  destination register.
rs1  input  4  source register 1 (CSR sub-op field for opcode 01001).
rs2  input  4  source register 2.
imm  input  18  immediate including modifier bits [17:16].
offset  input  27  branch/call offset.
imem_we  output  1  IMEM write strobe.
imem_addr  output  ADDR_W  IMEM write address.
imem_wdata  output  32  encoded instruction.
busy  output  1  session in progress.
prog_done  output  1  session finished; sticky until next start.
err_illegal  output  1  sticky; an illegal opcode was offered this session.
full  output  1  DEPTH words written this session.
word_count  output  ADDR_W+1  words written this session.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, including word_count, imem_addr and imem_wdata.
- States and transitions:
  - IDLE: start → ACCEPT. Latch base_addr into the address pointer, clear word_count/err_illegal/full/prog_done.
  - ACCEPT: in_ready=1 unless full.
    - On in_valid & in_ready with a legal op: register the encoded word and address → WRITE.
    - On an illegal op: set err_illegal, write nothing, pointer unchanged. If in_last → DONE, else stay in ACCEPT.
  - WRITE: imem_we=1 for exactly one cycle with the registered addr/data. Pointer+1 (wraps modulo 2^ADDR_W), word_count+1. If the registered bundle had in_last, or word_count reaches DEPTH → DONE, else → ACCEPT.
  - DONE: prog_done=1, busy=0. A start here begins a new session (same actions as from IDLE).
- busy=1 in ACCEPT and WRITE. in_ready=0 in IDLE, WRITE and DONE. Throughput is 1 word per 2 cycles. Latency from accept to imem_we is 1 cycle.
- A start pulse while busy is ignored.
- full=1 once word_count==DEPTH. The session then ends in DONE; no further bundles are accepted.
- Encoding, always word[31:27]=op:
  - Register format (op 00000–01100 incl. 01001): [26]=imm_en, [25:22]=rd, [21:18]=rs1.
    - imm_en=1: [17:0]=imm.
    - imm_en=0: [17:14]=rs2, [13:0]=0.
  - ld 01110 / st 01111: same as register format, but [26] is forced to 1.
  - beq 10000, bgt 10001, b 10010, call 10011: [26:0]=offset.
  - ret 10100, iret 10101: [26:0]=0.
  - 01101 and 10110–11111: illegal.
- Unused field inputs do not affect the encoded word.
- Bundle fields are sampled only on the accepting edge; changes afterwards have no effect.

Test Plan:
- start with base_addr=0x010, then add rd=3, rs1=1, rs2=2, imm_en=0 with in_last → one imem_we at addr 0x010, wdata 0x00C48000; prog_done=1, word_count=1.
- ld rd=5, rs1=2, imm=8 with imm_en=0 → wdata 0x75480008 ([26] forced). Next bundle beq offset=0x10 → addr+1, wdata 0x80000010. Then ret with in_last → wdata 0xA0000000, word_count=3.
- op=11000 mid-session → no imem_we, err_illegal=1, pointer unchanged. Next legal word is written at the same address.
- DEPTH=4, base_addr=0x3FE, 5 bundles offered → writes to 0x3FE, 0x3FF, 0x000, 0x001; full=1, DONE; fifth bundle sees in_ready=0.
- rst asserted during WRITE → imem_we drops immediately, all outputs 0, IDLE. A later start runs a clean session.
- start pulsed while in ACCEPT → ignored; pointer and word_count unchanged.
